fold_maj_seq: RTL

FOLD_MAJ_SEQ -- requirements
Module: fold_maj_seq

---
 rtl/fold_maj_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fold_maj_seq.sv
// -----------------------------------------------------------------------------
// fold_maj_seq
//
// Sequential (folded) majority classifier. A single CHUNK-bit popcount slice is
// reused over K = ceil(N/CHUNK) cycles to count the ones in an N-bit vector.
// The block then reports whether that count reaches THRESH.
//
// Handshake: valid/ready on both sides. Only one vector is in flight at a time.
//   IDLE  : in_ready=1; an accepted vector is latched into a shift buffer.
//   ACCUM : one chunk is added to the accumulator per clock.
//   DONE  : out_valid=1; out_y/out_count are held until out_ready.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   a vector is offered on in_x
//   in_ready   out  1   block can accept a vector (registered)
//   in_x       in   N   vector to classify
//   out_valid  out  1   result available (registered)
//   out_ready  in   1   consumer takes the result
//   out_y      out  1   majority decision, count >= THRESH (registered)
//   out_count  out  CW  ones counted at the decision point (registered)
//   busy       out  1   FSM is not in IDLE (registered)
//
// Configuration macro
//   FOLD_MAJ_EARLY_EXIT_EN : when defined, ACCUM stops as soon as the outcome
//   is settled. This happens when the partial sum already reaches THRESH, or
//   when it can no longer reach THRESH even if every remaining bit were set.
//   out_count then reports the partial sum. When the macro is undefined the
//   block always runs all K chunk cycles, and no early-exit logic exists.
// -----------------------------------------------------------------------------
module fold_maj_seq #(
  parameter int N      = 37,
  parameter int CHUNK  = 8,
  parameter int THRESH = (N + 1) / 2,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_y,
  output logic [CW-1:0] out_count,
  output logic          busy
);

  // Number of chunk cycles, and the width of the chunk index.
  localparam int K  = (N + CHUNK - 1) / CHUNK;
  localparam int JW = $clog2(K + 1);

  localparam logic [JW-1:0] LAST_J   = JW'(K - 1);
  localparam logic [CW:0]   THRESH_W = (CW + 1)'(THRESH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ones in one chunk. The result width CW is enough because CHUNK <= N.
  function automatic logic [CW-1:0] popcount_chunk(input logic [CHUNK-1:0] bits);
    logic [CW-1:0] sum;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum = sum + {{(CW - 1){1'b0}}, bits[i]};
    end
    return sum;
  endfunction

  state_t        state_r;
  logic [N-1:0]  buf_r;        // shift buffer; chunk j sits in the low CHUNK bits
  logic [CW-1:0] acc_r;        // running popcount, max value N so it never wraps
  logic [JW-1:0] j_r;          // index of the chunk being added
  logic          in_ready_r;
  logic          out_valid_r;
  logic          out_y_r;
  logic [CW-1:0] out_count_r;
  logic          busy_r;

  logic [CHUNK-1:0] chunk_bits_s;
  logic [CW-1:0]    chunk_pop_s;
  logic [CW-1:0]    acc_next_s;
  logic             last_chunk_s;
  logic             decide_s;
  logic             finish_s;

`ifdef FOLD_MAJ_EARLY_EXIT_EN
  localparam logic [CW-1:0] CHUNK_W = CW'(CHUNK);
  localparam logic [CW-1:0] N_W     = CW'(N);

  logic [CW-1:0] rem_r;        // input bits not yet added to acc_r
  logic [CW-1:0] rem_next_s;   // bits still remaining after this cycle's add
  logic          hit_s;
  logic          miss_s;
`endif

  // Chunk selection, popcount, next sum and end-of-accumulation decision.
  always_comb begin
    // Right shifts fill the buffer with zeros, so bits past N read as 0.
    chunk_bits_s = buf_r[CHUNK-1:0];
    chunk_pop_s  = popcount_chunk(chunk_bits_s);
    acc_next_s   = acc_r + chunk_pop_s;
    last_chunk_s = (j_r == LAST_J);
    decide_s     = ({1'b0, acc_next_s} >= THRESH_W);
`ifdef FOLD_MAJ_EARLY_EXIT_EN
    if (rem_r > CHUNK_W) begin
      rem_next_s = rem_r - CHUNK_W;
    end else begin
      rem_next_s = '0;
    end
    hit_s    = decide_s;
    // The outcome can no longer change if even all-ones in the rest stays short.
    miss_s   = (({1'b0, acc_next_s} + {1'b0, rem_next_s}) < THRESH_W);
    finish_s = last_chunk_s || hit_s || miss_s;
`else
    finish_s = last_chunk_s;
`endif
  end

  // Single FSM: sequencing plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      buf_r       <= '0;
      acc_r       <= '0;
      j_r         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_y_r     <= 1'b0;
      out_count_r <= '0;
      busy_r      <= 1'b0;
`ifdef FOLD_MAJ_EARLY_EXIT_EN
      rem_r       <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid_r <= 1'b0;
          if (in_valid && in_ready_r) begin
            buf_r      <= in_x;
            acc_r      <= '0;
            j_r        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_ACCUM;
`ifdef FOLD_MAJ_EARLY_EXIT_EN
            rem_r      <= N_W;
`endif
          end else begin
            // The first edge after reset release also lands here and raises in_ready.
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end

        ST_ACCUM: begin
          acc_r <= acc_next_s;
          j_r   <= j_r + JW'(1);
          buf_r <= buf_r >> CHUNK;
`ifdef FOLD_MAJ_EARLY_EXIT_EN
          rem_r <= rem_next_s;
`endif
          if (finish_s) begin
            out_valid_r <= 1'b1;
            out_y_r     <= decide_s;
            out_count_r <= acc_next_s;
            state_r     <= ST_DONE;
          end else begin
            state_r     <= ST_ACCUM;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DONE;
          end
        end

        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_y     = out_y_r;
  assign out_count = out_count_r;
  assign busy      = busy_r;

endmodule
